// File: rtl/framer_pkg.sv
// Shared types and constants for the serial word framer.
// Holds the FSM state type, the default sync word and the overflow width.
package framer_pkg;

  typedef enum logic {
    HUNT,
    LOCKED
  } framer_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         OVF_W        = 8;

endpackage

// File: rtl/serial_word_framer_if.sv
// Bit-stream in / word-stream out bundle for the serial word framer.
// master: bit source + word consumer; slave: the framer.
//   bit_in, bit_valid, resync  : serial input side
//   word_out, word_valid,
//   word_ready                 : buffered word handshake
//   locked, overflow_cnt       : status
interface serial_word_framer_if
  import framer_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             bit_in;
  logic             bit_valid;
  logic             resync;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             locked;
  logic [OVF_W-1:0] overflow_cnt;

  modport master (
    output bit_in,
    output bit_valid,
    output resync,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  locked,
    input  overflow_cnt
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  resync,
    input  word_ready,
    output word_out,
    output word_valid,
    output locked,
    output overflow_cnt
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with a registered head (no input-to-output path).
// Ports: i_push/i_push_data/o_full push side; o_valid/i_ready/o_data pop side.
module word_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic [1:0]       r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_data  = r_d0;
  assign w_pop   = o_valid & i_ready;
  // A full buffer still takes a word when the head leaves this cycle.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_push_data;
          else               r_d1 <= i_push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= i_push_data;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_framer.sv
// Hunts for SYNC in a serial stream, then packs bits MSB-first into words.
// Ports: clk, rst (sync, active-high), bus (serial_word_framer_if.slave).
module serial_word_framer
  import framer_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = WIDTH'(SYNC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_framer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  framer_state_t    r_state;
  framer_state_t    w_state_nx;
  logic [WIDTH-1:0] r_hunt_sh;
  logic [CW-1:0]    r_hunt_cnt;
  logic [WIDTH-1:0] r_asm;
  logic [CW-1:0]    r_bit_cnt;
  logic [OVF_W-1:0] r_ovf;

  logic             w_take;
  logic [WIDTH-1:0] w_hunt_nx;
  logic [WIDTH-1:0] w_asm_nx;
  logic             w_match;
  logic             w_word_done;
  logic             w_full;
  logic             w_fifo_valid;
  logic             w_drop;

  // resync swallows any bit arriving in the same cycle.
  assign w_take    = bus.bit_valid & ~bus.resync;
  assign w_hunt_nx = {r_hunt_sh[WIDTH-2:0], bus.bit_in};
  assign w_asm_nx  = {r_asm[WIDTH-2:0], bus.bit_in};

  // Counter already holding WIDTH-1 means this bit completes a full window.
  assign w_match = w_take
                 & (r_state == HUNT)
                 & (w_hunt_nx == SYNC)
                 & (r_hunt_cnt >= CW'(WIDTH - 1));

  assign w_word_done = w_take
                     & (r_state == LOCKED)
                     & (r_bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      HUNT:    if (w_match) w_state_nx = LOCKED;
      LOCKED:  w_state_nx = LOCKED;
      default: w_state_nx = HUNT;
    endcase
    if (bus.resync) w_state_nx = HUNT;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.resync) begin
      r_hunt_sh  <= '0;
      r_hunt_cnt <= '0;
      r_asm      <= '0;
      r_bit_cnt  <= '0;
    end else if (w_take) begin
      if (r_state == HUNT) begin
        r_hunt_sh <= w_hunt_nx;
        if (r_hunt_cnt != CW'(WIDTH))
          r_hunt_cnt <= r_hunt_cnt + CW'(1);
        if (w_match)
          r_bit_cnt <= '0;
      end else begin
        r_asm <= w_asm_nx;
        if (w_word_done) r_bit_cnt <= '0;
        else             r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  word_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_word_done),
    .i_push_data (w_asm_nx),
    .o_full      (w_full),
    .o_valid     (w_fifo_valid),
    .i_ready     (bus.word_ready),
    .o_data      (bus.word_out)
  );

  assign w_drop = w_word_done & w_full & ~bus.word_ready;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= '0;
    else if (w_drop && (r_ovf != '1))
      r_ovf <= r_ovf + OVF_W'(1);
  end

  assign bus.word_valid   = w_fifo_valid;
  assign bus.locked       = (r_state == LOCKED);
  assign bus.overflow_cnt = r_ovf;

endmodule

// File: tb/tb_serial_word_framer.sv
// Self-checking bench for serial_word_framer against a queue-based model.
// Directed test-plan scenarios followed by randomized traffic.
module tb_serial_word_framer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_word_framer_if #(.WIDTH(W)) bus ();

  serial_word_framer #(
    .WIDTH (W),
    .SYNC  (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit         m_locked;
  bit         m_hist[$];
  int         m_word;
  int         m_n;
  logic [7:0] m_q[$];
  int         m_ovf;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic b, input logic v,
                       input logic rs, input logic rdy,
                       input logic r);
    bit pop;
    bit push;
    int pv;
    int hv;
    push = 0;
    pv   = 0;
    if (r) begin
      m_locked = 0;
      m_hist.delete();
      m_word = 0;
      m_n    = 0;
      m_q.delete();
      m_ovf  = 0;
      return;
    end
    pop = rdy && (m_q.size() > 0);
    if (rs) begin
      m_locked = 0;
      m_hist.delete();
      m_word = 0;
      m_n    = 0;
    end else if (v) begin
      if (!m_locked) begin
        m_hist.push_back(b);
        if (m_hist.size() > W) void'(m_hist.pop_front());
        if (m_hist.size() == W) begin
          hv = 0;
          foreach (m_hist[k]) hv = hv * 2 + int'(m_hist[k]);
          if (hv == 'hA5) begin
            m_locked = 1;
            m_word   = 0;
            m_n      = 0;
          end
        end
      end else begin
        m_word = (m_word * 2 + int'(b)) % 256;
        m_n++;
        if (m_n == W) begin
          push = 1;
          pv   = m_word;
          m_n  = 0;
          m_word = 0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(8'(pv));
      else if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic step(input logic b, input logic v,
                      input logic rs, input logic rdy,
                      input logic r);
    bus.bit_in     = b;
    bus.bit_valid  = v;
    bus.resync     = rs;
    bus.word_ready = rdy;
    rst            = r;
    @(posedge clk);
    model(b, v, rs, rdy, r);
    #1;
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("valid", 32'(bus.word_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0)
      chk("word", 32'(bus.word_out), 32'(m_q[0]));
    chk("ovf", 32'(bus.overflow_cnt), 32'(m_ovf));
    if (r) chk("rst_word", 32'(bus.word_out), 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] bv, input bit gap,
                           input logic rdy, input logic last_rdy);
    logic [7:0] d;
    d = bv;
    for (int i = 7; i >= 0; i--) begin
      if (gap) step(1'($urandom), 1'b0, 1'b0, rdy, 1'b0);
      step(d[i], 1'b1, 1'b0, (i == 0) ? last_rdy : rdy, 1'b0);
    end
  endtask

  initial begin
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.resync     = 1'b0;
    bus.word_ready = 1'b0;

    // Reset with bit_valid high.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_locked", 32'(bus.locked), 32'h0);

    // Lock and first word.
    send_byte(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("lock_rise", 32'(bus.locked), 32'h1);
    send_byte(8'h3C, 1'b0, 1'b1, 1'b1);
    chk("first_word", 32'(bus.word_out), 32'h3C);
    chk("first_valid", 32'(bus.word_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("one_cycle", 32'(bus.word_valid), 32'h0);

    // Gapped input after resync.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("resync_drop", 32'(bus.locked), 32'h0);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("gap_word", 32'(bus.word_out), 32'h3C);

    // Backpressure and overflow.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    chk("bp_head", 32'(bus.word_out), 32'h11);
    chk("bp_ovf", 32'(bus.overflow_cnt), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_second", 32'(bus.word_out), 32'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_empty", 32'(bus.word_valid), 32'h0);

    // Full buffer, push and pop in the same cycle.
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b1);
    chk("pp_head", 32'(bus.word_out), 32'h22);
    chk("pp_ovf", 32'(bus.overflow_cnt), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_third", 32'(bus.word_out), 32'h44);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // resync mid-word.
    for (int i = 0; i < 4; i++)
      step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_resync", 32'(bus.locked), 32'h0);
    send_byte(8'hA5, 1'b0, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("rs_word", 32'(bus.word_out), 32'h5A);
    chk("rs_valid", 32'(bus.word_valid), 32'h1);

    // Overflow saturation.
    for (int i = 0; i < 300; i++)
      send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("ovf_sat", 32'(bus.overflow_cnt), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional sync words, resyncs and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        send_byte(8'hA5, 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom));
      else
        step(1'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 99) == 0),
             1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
